// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: pipeline writeback has priority over a one-entry buffer of
// multi-cycle unit results; a starved buffered result requests a writeback bubble.
module grf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc4,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [31:0] aux_pc4,
    output logic        RegWrite,
    output logic [4:0]  rtd,
    output logic [31:0] busW,
    output logic [31:0] PC4,
    output logic        pend_valid,
    output logic [4:0]  pend_addr,
    output logic        wb_stall
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic        pend_valid_reg, pend_valid_next;
    logic [4:0]  pend_addr_reg;
    logic [31:0] pend_data_reg, pend_pc4_reg;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        wb_stall_reg, wb_stall_next;
    logic        regwrite_reg;
    logic [4:0]  rtd_reg;
    logic [31:0] busw_reg, pc4_reg;

    logic issue_wb, issue_buf, accept, kill, still_waiting;

    assign issue_wb      = wb_we && (wb_addr != 5'd0);
    assign issue_buf     = !issue_wb && pend_valid_reg;
    assign accept        = aux_valid && !pend_valid_reg;
    // A younger pipeline write to the same register makes the buffered value dead.
    assign kill          = issue_wb && pend_valid_reg && (wb_addr == pend_addr_reg);
    assign still_waiting = pend_valid_reg && !issue_buf && !kill;

    always_comb begin
        pend_valid_next = pend_valid_reg;
        wait_cnt_next   = wait_cnt_reg;
        wb_stall_next   = 1'b0;
        if (accept) begin
            pend_valid_next = (aux_addr != 5'd0);
            wait_cnt_next   = 8'd0;
        end else if (still_waiting) begin
            wait_cnt_next   = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
            wb_stall_next   = (wait_cnt_reg >= LIMIT);
        end else begin
            pend_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= 5'd0;
            pend_data_reg  <= 32'd0;
            pend_pc4_reg   <= 32'd0;
            wait_cnt_reg   <= 8'd0;
            wb_stall_reg   <= 1'b0;
            regwrite_reg   <= 1'b0;
            rtd_reg        <= 5'd0;
            busw_reg       <= 32'd0;
            pc4_reg        <= 32'd0;
        end else begin
            pend_valid_reg <= pend_valid_next;
            wait_cnt_reg   <= wait_cnt_next;
            wb_stall_reg   <= wb_stall_next;
            // $0 results are consumed without touching the buffer contents.
            if (accept && (aux_addr != 5'd0)) begin
                pend_addr_reg <= aux_addr;
                pend_data_reg <= aux_data;
                pend_pc4_reg  <= aux_pc4;
            end
            regwrite_reg <= issue_wb || issue_buf;
            if (issue_wb) begin
                rtd_reg  <= wb_addr;
                busw_reg <= wb_data;
                pc4_reg  <= wb_pc4;
            end else if (issue_buf) begin
                rtd_reg  <= pend_addr_reg;
                busw_reg <= pend_data_reg;
                pc4_reg  <= pend_pc4_reg;
            end
        end
    end

    assign aux_ready  = !pend_valid_reg;
    assign pend_valid = pend_valid_reg;
    assign pend_addr  = pend_addr_reg;
    assign wb_stall   = wb_stall_reg;
    assign RegWrite   = regwrite_reg;
    assign rtd        = rtd_reg;
    assign busW       = busw_reg;
    assign PC4        = pc4_reg;
endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed test-plan steps followed by randomized traffic, checked each cycle against
// a behavioural model of the arbiter rules.
module tb_grf_write_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_pc4;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data, aux_pc4;
    logic        RegWrite;
    logic [4:0]  rtd;
    logic [31:0] busW, PC4;
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic        wb_stall;

    int checks = 0;
    int errors = 0;

    // model state
    bit          m_rw;
    logic [4:0]  m_rtd;
    logic [31:0] m_busw, m_pc4;
    bit          m_pv;
    logic [4:0]  m_pa;
    logic [31:0] m_pd, m_pp;
    int          m_age;
    bit          m_stall;

    grf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc4(wb_pc4),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr),
        .aux_data(aux_data), .aux_pc4(aux_pc4),
        .RegWrite(RegWrite), .rtd(rtd), .busW(busW), .PC4(PC4),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the arbiter rules applied to the currently driven inputs.
    task automatic model_update();
        bit wb_go, buf_go, accept, waiting;
        if (reset) begin
            m_rw = 0; m_rtd = '0; m_busw = '0; m_pc4 = '0;
            m_pv = 0; m_pa = '0; m_pd = '0; m_pp = '0; m_age = 0; m_stall = 0;
            return;
        end
        wb_go   = wb_we && (wb_addr != 0);
        buf_go  = !wb_go && m_pv;
        accept  = aux_valid && !m_pv;
        waiting = m_pv && !buf_go && !(wb_go && wb_addr == m_pa);
        m_rw = wb_go || buf_go;
        if (wb_go) begin
            m_rtd = wb_addr; m_busw = wb_data; m_pc4 = wb_pc4;
        end else if (buf_go) begin
            m_rtd = m_pa; m_busw = m_pd; m_pc4 = m_pp;
        end
        m_stall = waiting && (m_age >= LIMIT);
        if (waiting) begin
            if (m_age < 255) m_age++;
        end else if (accept) begin
            m_age = 0;
            m_pv  = (aux_addr != 0);
            if (aux_addr != 0) begin
                m_pa = aux_addr; m_pd = aux_data; m_pp = aux_pc4;
            end
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic check_all();
        chk("RegWrite", RegWrite, m_rw);
        chk("rtd", rtd, m_rtd);
        chk("busW", busW, m_busw);
        chk("PC4", PC4, m_pc4);
        chk("pend_valid", pend_valid, m_pv);
        chk("aux_ready", aux_ready, !m_pv);
        chk("wb_stall", wb_stall, m_stall);
        if (m_pv) chk("pend_addr", pend_addr, m_pa);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        reset = 0; wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc4 = 0;
        aux_valid = 0; aux_addr = 0; aux_data = 0; aux_pc4 = 0;
    endtask

    task automatic rand_inputs();
        wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom; wb_pc4 = $urandom;
        aux_valid = 1'($urandom); aux_addr = 5'($urandom);
        aux_data = $urandom; aux_pc4 = $urandom;
    endtask

    initial begin
        // Reset with random inputs
        rand_inputs();
        reset = 1;
        step();
        rand_inputs();
        step();
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_pend_valid", pend_valid, 0);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_aux_ready", aux_ready, 1);
        chk("rst_busW", busW, 0);
        chk("rst_rtd", rtd, 0);
        chk("rst_PC4", PC4, 0);

        // Plain WB, then WB to $0
        idle_inputs();
        wb_we = 1; wb_addr = 8; wb_data = 32'h1234; wb_pc4 = 32'h3004;
        step();
        chk("wb_RegWrite", RegWrite, 1);
        chk("wb_rtd", rtd, 8);
        chk("wb_busW", busW, 32'h1234);
        chk("wb_PC4", PC4, 32'h3004);
        wb_addr = 0; wb_data = 32'hFFFF;
        step();
        chk("wb0_RegWrite", RegWrite, 0);

        // Aux with idle pipeline
        idle_inputs();
        aux_valid = 1; aux_addr = 9; aux_data = 32'hABCD; aux_pc4 = 32'h4008;
        step();
        chk("aux_pend_valid", pend_valid, 1);
        chk("aux_ready_low", aux_ready, 0);
        aux_valid = 0;
        step();
        chk("aux_RegWrite", RegWrite, 1);
        chk("aux_rtd", rtd, 9);
        chk("aux_busW", busW, 32'hABCD);

        // Aux $0 is consumed without buffering
        aux_valid = 1; aux_addr = 0; aux_data = 32'h77;
        step();
        chk("aux0_pend_valid", pend_valid, 0);
        aux_valid = 0;
        step();
        chk("aux0_RegWrite", RegWrite, 0);

        // Contention and starvation
        aux_valid = 1; aux_addr = 7; aux_data = 32'h7777; aux_pc4 = 32'h5000;
        wb_we = 1; wb_addr = 5; wb_data = 32'h5555;
        step();
        aux_valid = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            wb_data = 32'h5000 + i;
            step();
            chk("starve_stall_low", wb_stall, 0);
        end
        step();
        chk("starve_stall_high", wb_stall, 1);
        step();
        chk("stall_wb_wins_rtd", rtd, 5);
        chk("stall_stays", wb_stall, 1);
        wb_we = 0;
        step();
        chk("drain_rtd", rtd, 7);
        chk("drain_busW", busW, 32'h7777);
        chk("drain_stall_low", wb_stall, 0);

        // WAW kill
        idle_inputs();
        aux_valid = 1; aux_addr = 12; aux_data = 32'h99;
        step();
        aux_valid = 0; wb_we = 1; wb_addr = 12; wb_data = 32'h55;
        step();
        chk("waw_busW", busW, 32'h55);
        chk("waw_pend_valid", pend_valid, 0);
        wb_we = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("waw_no_write", RegWrite, 0);
        end

        // Reset mid-operation with a starved entry
        aux_valid = 1; aux_addr = 3; aux_data = 32'hDEAD;
        wb_we = 1; wb_addr = 5;
        step();
        aux_valid = 0;
        for (int i = 0; i <= LIMIT; i++) step();
        chk("mid_stall_high", wb_stall, 1);
        wb_we = 0; reset = 1;
        step();
        chk("mid_pend_cleared", pend_valid, 0);
        chk("mid_stall_cleared", wb_stall, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_write", RegWrite, 0);
        end

        // Randomized traffic with alternating WB pressure
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            wb_we = ($urandom_range(0, 99) < ((i / 300) % 2 ? 90 : 50));
            if ($urandom_range(0, 7) == 0) wb_addr = m_pa;
            reset = ($urandom_range(0, 127) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Producer side of the GRF write port: merges the pipeline writeback stream with results from multi-cycle units (MDU, future coprocessors) into the single write port (`RegWrite`, `rtd`, `busW`, `PC4`) the register file consumes. The pipeline writeback has priority. Multi-cycle results are held in a one-entry buffer. If the buffer waits too long, a stall request forces a writeback bubble. The block sits between the W stage and the GRF, and exports the buffered destination to the hazard unit.

## Interface

Parameters:
- `STARVE_LIMIT`, default 4 — cycles a buffered aux result may wait before `wb_stall` is raised. Legal range 1..255.

Ports:
- `clk` input 1 — the block's single clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-high.
- `wb_we` input 1 — pipeline writeback request.
- `wb_addr` input 5 — pipeline destination register.
- `wb_data` input 32 — pipeline write data.
- `wb_pc4` input 32 — PC+4 of the writing instruction.
- `aux_valid` input 1 — multi-cycle unit offers a result.
- `aux_ready` output 1 — buffer can accept; equals `~pend_valid`.
- `aux_addr` input 5 — aux destination register.
- `aux_data` input 32 — aux result.
- `aux_pc4` input 32 — aux PC+4.
- `RegWrite` output 1 — registered GRF write enable.
- `rtd` output 5 — registered GRF write address.
- `busW` output 32 — registered GRF write data.
- `PC4` output 32 — registered PC+4 passed to the GRF.
- `pend_valid` output 1 — aux result is buffered, not yet written.
- `pend_addr` output 5 — destination of the buffered result.
- `wb_stall` output 1 — registered request for the pipeline to insert a writeback bubble.

## Operation

State:
- Buffer: `pend_valid`, `pend_addr`, data, and pc4.
- 8-bit wait counter `wait_cnt`.
- Output registers.

Per cycle:
- **Issue select:**
  - If `wb_we && wb_addr != 0`, issue WB.
  - Else if `pend_valid`, issue BUF.
  - Else issue NONE.
- **Output registers:**
  - Issue WB or BUF: load `RegWrite=1` and the chosen `rtd`, `busW`, `PC4`.
  - Issue NONE: load `RegWrite=0`. `rtd`, `busW`, `PC4` hold their previous values.
- **$0 writes:** always discarded from either source and never produce `RegWrite=1`. An aux handshake with `aux_addr=0` is consumed but does not set `pend_valid`.
- **Accept:** on `aux_valid && aux_ready`, load the buffer and clear `wait_cnt`. Accept cannot happen while `pend_valid`=1, even in a cycle where BUF issues. The freed slot is visible the following cycle.
- **Drain:** issue BUF clears `pend_valid`.
- **WAW kill:** if WB issues with `wb_addr == pend_addr` while `pend_valid`, the buffered entry is dropped (`pend_valid` cleared). The pipeline write is the younger value.
- **Starvation:**
  - `wait_cnt` increments, saturating at 255, each cycle `pend_valid` stays set and BUF does not issue.
  - `wb_stall` is registered and is 1 in the cycle after `wait_cnt` reaches `STARVE_LIMIT`.
  - `wb_stall` is 0 in the cycle after BUF issues or the entry is killed.
  - A WB arriving while `wb_stall`=1 still wins; the stall stays up.
- **Reset:** clears all registers and outputs to 0. `aux_ready` is 1 in the first cycle after reset. A buffered entry present at reset is lost.

## Timing

- **WB latency:** request in cycle N appears on `RegWrite`/`rtd`/`busW`/`PC4` in cycle N+1; the GRF commits at the end of N+1.
- **Aux latency:** accept in cycle N sets `pend_valid` in N+1. With no WB contention, BUF issues in N+1 and the output is visible in N+2.
- **Throughput:**
  - WB: one write per cycle, no backpressure.
  - Aux: at most one accept every 2 cycles.
- `pend_valid`, `pend_addr`, and `aux_ready` are register-driven, with no combinational path from any input.
- **Stall:** `wb_stall` rises at the earliest `STARVE_LIMIT`+1 cycles after `pend_valid` rises under continuous WB traffic.

## Test plan

- **Reset:** hold `reset` for 2 cycles with random inputs. Then `RegWrite=0`, `pend_valid=0`, `wb_stall=0`, `aux_ready=1`, and outputs are 0.
- **Plain WB:** `wb_we=1`, addr 8, data 0x1234, pc4 0x3004 in cycle N. In N+1, `RegWrite=1`, `rtd=8`, `busW=0x1234`, `PC4=0x3004`. A WB to addr 0 yields `RegWrite=0`.
- **Aux with idle pipeline:**
  - Aux valid, addr 9, data 0xABCD, accepted in N.
  - `pend_valid=1` and `aux_ready=0` in N+1.
  - In N+2, `RegWrite=1`, `rtd=9`, `busW=0xABCD`.
- **Contention:**
  - Aux accepted, then continuous WB to addr 5 with `STARVE_LIMIT=4`.
  - `wb_stall` rises as specified in Operation.
  - Dropping `wb_we` for one cycle lets BUF issue in the following cycle.
  - `wb_stall` falls the cycle after BUF issues.
- **WAW kill:** buffered aux to addr 12, then WB to addr 12 data 0x55. Output shows `busW=0x55` only, `pend_valid` clears, and no later write to 12 occurs.
- **Reset mid-operation:** aux buffered and `wb_stall=1`, then assert `reset` for 1 cycle. The buffer is cleared, `wb_stall=0`, and no write of the buffered data ever appears.
